// File: rtl/clock_set_pkg.sv
// Shared encodings and field limits for the time-of-day controller.
package clock_set_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_t;

endpackage

// File: rtl/mod_n_en_cnt.sv
// Enabled modulo-(MAX+1) counter with synchronous clear and a combinational terminal-count carry.
module mod_n_en_cnt #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  assign tc = en & (cnt == MAX_V);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (clr)      cnt <= '0;
    else if (en)       cnt <= (cnt == MAX_V) ? '0 : cnt + WIDTH'(1);
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// 24-hour clock: 1 Hz divider, sec/min/hour cascade and a RUN/SET_HOUR/SET_MIN edit FSM.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int DIV_BITS = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_p,
  input  logic              inc_p,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic [1:0]        state,
  output logic              day_p
);

  localparam logic [DIV_BITS-1:0] DIV_MAX = DIV_BITS'(TICK_DIV - 1);

  state_t              st, st_nxt;
  logic [DIV_BITS-1:0] div;
  logic                run, tick;
  logic                sec_en, sec_clr, min_en, hour_en;
  logic                sec_tc, min_tc, hour_tc;

  assign state = st;
  assign tick  = (st == ST_RUN) && (div == DIV_MAX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= ST_RUN;
    else      st <= st_nxt;
  end

  // Next-state: only mode_p moves the FSM; the unused code recovers to RUN
  always_comb begin
    st_nxt = st;
    case (st)
      ST_RUN:      if (mode_p) st_nxt = ST_SET_HOUR;
      ST_SET_HOUR: if (mode_p) st_nxt = ST_SET_MIN;
      ST_SET_MIN:  if (mode_p) st_nxt = ST_RUN;
      default:     st_nxt = ST_RUN;
    endcase
  end

  // Counter enables: cascade in RUN, inc_p steers to the edited field otherwise (mode_p wins)
  always_comb begin
    run     = 1'b0;
    sec_en  = 1'b0;
    sec_clr = 1'b0;
    min_en  = 1'b0;
    hour_en = 1'b0;
    case (st)
      ST_RUN: begin
        run     = 1'b1;
        sec_en  = tick;
        min_en  = sec_tc;
        hour_en = min_tc;
      end
      ST_SET_HOUR: hour_en = inc_p & ~mode_p;
      ST_SET_MIN: begin
        min_en  = inc_p & ~mode_p;
        sec_clr = mode_p;
      end
      default: ;
    endcase
  end

  // Divider sits at 0 outside RUN so the first tick after editing is a full period away
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        div <= '0;
    else if (!run || mode_p || tick) div <= '0;
    else                             div <= div + DIV_BITS'(1);
  end

  // A rollover on the same edge that leaves RUN is dropped so day_p never shows in a set state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) day_p <= 1'b0;
    else      day_p <= run & hour_tc & ~mode_p;
  end

  mod_n_en_cnt #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .en(sec_en), .clr(sec_clr), .cnt(sec), .tc(sec_tc)
  );

  mod_n_en_cnt #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .en(min_en), .clr(1'b0), .cnt(min), .tc(min_tc)
  );

  mod_n_en_cnt #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .rst(rst), .en(hour_en), .clr(1'b0), .cnt(hour), .tc(hour_tc)
  );

endmodule
